// File: rtl/dsp_mult_sched.sv
// Round-robin scheduler that time-shares one DSP48E1 multiplier among N_REQ requesters.
// A tag pipeline follows the DSP registers, so every product comes back with the id of its requester.
module dsp_mult_sched #(
  parameter int N_REQ = 4,
  parameter int LAT   = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*25-1:0]       req_a,
  input  logic [N_REQ*18-1:0]       req_b,
  output logic [29:0]               dsp_a,
  output logic [17:0]               dsp_b,
  output logic [6:0]                dsp_opmode,
  output logic [3:0]                dsp_alumode,
  output logic                      dsp_ce,
  input  logic [47:0]               dsp_p,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [$clog2(N_REQ)-1:0]  res_id,
  output logic [42:0]               res_data,
  output logic [31:0]               ops_done
);

  localparam int             IDW     = $clog2(N_REQ);
  localparam logic [IDW:0]   N_REQ_W = (IDW+1)'(N_REQ);

  logic [IDW-1:0]            rr_ptr_q, rr_ptr_d;
  logic [LAT-1:0]            tag_vld_q, tag_vld_d;
  logic [LAT-1:0][IDW-1:0]   tag_id_q, tag_id_d;
  logic [31:0]               ops_done_q, ops_done_d;

  logic [N_REQ-1:0]          rot;
  logic                      gnt_found;
  logic [IDW:0]              gnt_sum;
  logic [IDW-1:0]            gnt_id;
  logic [IDW:0]              rr_sum;
  logic                      stall;
  logic                      xfer;
  logic [24:0]               a_sel;
  logic [17:0]               b_sel;
  logic                      unused_p;

  assign unused_p = ^dsp_p[47:43];

  assign stall       = res_valid & ~res_ready;
  assign dsp_ce      = ~stall;
  assign dsp_opmode  = 7'b0000101;
  assign dsp_alumode = 4'b0000;

  // Rotate the valid vector so bit 0 is the requester at rr_ptr; first set bit wins.
  always_comb begin
    rot       = N_REQ'({req_valid, req_valid} >> rr_ptr_q);
    gnt_found = 1'b0;
    gnt_sum   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!gnt_found && rot[k]) begin
        gnt_found = 1'b1;
        gnt_sum   = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      end
    end
    if (gnt_sum >= N_REQ_W) begin
      gnt_sum = gnt_sum - N_REQ_W;
    end
    gnt_id = gnt_sum[IDW-1:0];
  end

  // No handshake while in reset, so nothing can be issued into a DSP we are about to ignore.
  assign xfer = gnt_found & ~stall & rst_n;

  always_comb begin
    req_ready = '0;
    a_sel     = '0;
    b_sel     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (xfer && (gnt_id == IDW'(i))) begin
        req_ready[i] = 1'b1;
        a_sel        = req_a[i*25 +: 25];
        b_sel        = req_b[i*18 +: 18];
      end
    end
  end

  assign dsp_a = {{5{a_sel[24]}}, a_sel};
  assign dsp_b = b_sel;

  always_comb begin
    rr_sum   = {1'b0, gnt_id} + (IDW+1)'(1);
    if (rr_sum >= N_REQ_W) begin
      rr_sum = '0;
    end
    rr_ptr_d = xfer ? rr_sum[IDW-1:0] : rr_ptr_q;
  end

  // Tags move only with dsp_ce so they stay lined up with the A/B/M registers.
  always_comb begin
    tag_vld_d = tag_vld_q;
    tag_id_d  = tag_id_q;
    if (dsp_ce) begin
      tag_vld_d[0] = xfer;
      tag_id_d[0]  = xfer ? gnt_id : '0;
      for (int k = 1; k < LAT; k++) begin
        tag_vld_d[k] = tag_vld_q[k-1];
        tag_id_d[k]  = tag_id_q[k-1];
      end
    end
  end

  always_comb begin
    ops_done_d = ops_done_q;
    if (res_valid && res_ready) begin
      ops_done_d = ops_done_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      tag_vld_q  <= '0;
      tag_id_q   <= '0;
      ops_done_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      tag_vld_q  <= tag_vld_d;
      tag_id_q   <= tag_id_d;
      ops_done_q <= ops_done_d;
    end
  end

  assign res_valid = tag_vld_q[LAT-1];
  assign res_id    = tag_id_q[LAT-1];
  assign res_data  = dsp_p[42:0];
  assign ops_done  = ops_done_q;

endmodule

// File: tb/tb_dsp_mult_sched.sv
// Bench for dsp_mult_sched: a behavioural DSP48E1 (AREG=2, MREG=1, PREG=0) plus a queue-based
// reference model of arbitration, latency, back-pressure and the result counter.
module tb_dsp_mult_sched;

  localparam int N   = 4;
  localparam int LAT = 3;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [99:0]  req_a;
  logic [71:0]  req_b;
  logic [29:0]  dsp_a;
  logic [17:0]  dsp_b;
  logic [6:0]   dsp_opmode;
  logic [3:0]   dsp_alumode;
  logic         dsp_ce;
  logic [47:0]  dsp_p;
  logic         res_valid;
  logic         res_ready;
  logic [1:0]   res_id;
  logic [42:0]  res_data;
  logic [31:0]  ops_done;

  dsp_mult_sched #(.N_REQ(N), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .dsp_a(dsp_a), .dsp_b(dsp_b),
    .dsp_opmode(dsp_opmode), .dsp_alumode(dsp_alumode),
    .dsp_ce(dsp_ce), .dsp_p(dsp_p),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_id(res_id), .res_data(res_data),
    .ops_done(ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DSP48E1 model: A1/A2, B1/B2, M registers, P combinational, no reset (stale contents survive).
  logic [29:0]         a1_r = '0, a2_r = '0;
  logic [17:0]         b1_r = '0, b2_r = '0;
  logic signed [47:0]  m_r  = '0;
  wire  signed [47:0]  ax = {{18{a2_r[29]}}, a2_r};
  wire  signed [47:0]  bx = {{30{b2_r[17]}}, b2_r};

  always @(posedge clk) begin
    if (dsp_ce) begin
      a1_r <= dsp_a;
      a2_r <= a1_r;
      b1_r <= dsp_b;
      b2_r <= b1_r;
      m_r  <= ax * bx;
    end
  end
  assign dsp_p = m_r;

  int          checks = 0;
  int          errors = 0;
  logic [24:0] a_in [4];
  logic [17:0] b_in [4];

  int          q_id   [$];
  logic [42:0] q_data [$];
  int          q_age  [$];
  int          rr_m   = 0;
  logic [31:0] ops_m  = '0;
  int          seen   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (ptr + k) % N;
      if (((v >> idx) & 4'd1) != 4'd0) return idx;
    end
    return -1;
  endfunction

  function automatic logic [42:0] product(input logic [24:0] a, input logic [17:0] b);
    longint av, bv, p;
    av = longint'($signed(a));
    bv = longint'($signed(b));
    p  = av * bv;
    return p[42:0];
  endfunction

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      req_a[i*25 +: 25] = a_in[i];
      req_b[i*18 +: 18] = b_in[i];
    end
  endtask

  // One clock: settle, compare against the model, advance the model, end on the next negedge.
  task automatic tick();
    logic       exp_valid, exp_stall;
    int         g;
    logic [3:0] exp_rdy;
    apply();
    #2;
    if (!rst_n) begin
      q_id.delete(); q_data.delete(); q_age.delete();
      rr_m  = 0;
      ops_m = '0;
    end
    exp_valid = 1'b0;
    if (rst_n && q_id.size() > 0) exp_valid = (q_age[0] == LAT-1);
    exp_stall = exp_valid && !res_ready;
    g         = (rst_n && !exp_stall) ? pick(req_valid, rr_m) : -1;
    exp_rdy   = (g >= 0) ? (4'd1 << g) : 4'd0;

    check("res_valid", 64'(res_valid), 64'(exp_valid));
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    check("dsp_ce",    64'(dsp_ce),    64'(!exp_stall));
    check("ops_done",  64'(ops_done),  64'(ops_m));
    if (exp_valid) begin
      check("res_id",   64'(res_id),   64'(q_id[0]));
      check("res_data", 64'(res_data), 64'(q_data[0]));
    end
    if (!rst_n) check("res_id_rst", 64'(res_id), 64'd0);
    if (g >= 0) begin
      check("dsp_a", 64'(dsp_a), 64'({{5{a_in[g][24]}}, a_in[g]}));
      check("dsp_b", 64'(dsp_b), 64'(b_in[g]));
    end else begin
      check("dsp_a_idle", 64'({dsp_a, dsp_b}), 64'd0);
    end

    if (rst_n && !exp_stall) begin
      if (exp_valid && res_ready) begin
        void'(q_id.pop_front()); void'(q_data.pop_front()); void'(q_age.pop_front());
        ops_m = ops_m + 32'd1;
        seen++;
      end
      foreach (q_age[i]) q_age[i]++;
      if (g >= 0) begin
        q_id.push_back(g);
        q_data.push_back(product(a_in[g], b_in[g]));
        q_age.push_back(0);
        rr_m = (g + 1) % N;
      end
    end
    @(negedge clk);
  endtask

  logic [42:0] snap_data;
  logic [1:0]  snap_id;
  logic [42:0] exp_d;
  int          seen0;

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    res_ready = 1'b1;
    req_a     = '0;
    req_b     = '0;
    for (int i = 0; i < N; i++) begin a_in[i] = '0; b_in[i] = '0; end
    @(negedge clk);

    // Reset outputs with requests pending
    req_valid = 4'b1111;
    #1;
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_dsp_ce",    64'(dsp_ce),    64'd1);
    check("rst_ops_done",  64'(ops_done),  64'd0);
    check("opmode",        64'(dsp_opmode),  64'h05);
    check("alumode",       64'(dsp_alumode), 64'h0);
    tick();
    tick();
    rst_n = 1'b1;

    // All four valid from reset: grants rotate 0,1,2,3 with back-to-back results
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < N; i++) begin
        a_in[i] = 25'($urandom);
        b_in[i] = 18'($urandom);
      end
      apply();
      #1;
      check("rr_order", 64'(req_ready), 64'(4'd1 << (k % 4)));
      if (k >= LAT) begin
        check("b2b_valid", 64'(res_valid), 64'd1);
        check("b2b_id",    64'(res_id),    64'((k - LAT) % 4));
      end
      tick();
    end
    req_valid = '0;
    repeat (4) tick();

    // Single requester 0: 3 * -5
    a_in[0]   = 25'd3;
    b_in[0]   = -18'sd5;
    req_valid = 4'b0001;
    apply();
    #1;
    check("single_ready", 64'(req_ready), 64'd1);
    tick();
    req_valid = '0;
    for (int k = 1; k < LAT; k++) begin
      #1;
      check("single_early", 64'(res_valid), 64'd0);
      tick();
    end
    #1;
    exp_d = -43'sd15;
    check("single_valid", 64'(res_valid), 64'd1);
    check("single_id",    64'(res_id),    64'd0);
    check("single_data",  64'(res_data),  64'(exp_d));
    tick();

    // Back-pressure with three results in flight
    res_ready = 1'b0;
    req_valid = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      a_in[0] = 25'($urandom);
      b_in[0] = 18'($urandom);
      tick();
    end
    req_valid = 4'b0010;
    a_in[1]   = 25'($urandom);
    b_in[1]   = 18'($urandom);
    apply();
    #1;
    snap_data = res_data;
    snap_id   = res_id;
    for (int s = 0; s < 5; s++) begin
      #1;
      check("stall_ce",    64'(dsp_ce),    64'd0);
      check("stall_ready", 64'(req_ready), 64'd0);
      check("stall_valid", 64'(res_valid), 64'd1);
      check("stall_id",    64'(res_id),    64'(snap_id));
      check("stall_data",  64'(res_data),  64'(snap_data));
      tick();
    end
    res_ready = 1'b1;
    req_valid = '0;
    seen0     = seen;
    repeat (6) tick();
    check("stall_drained", 64'(seen - seen0), 64'd3);

    // Extreme operands
    a_in[2]   = 25'h1000000;
    b_in[2]   = 18'h20000;
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    repeat (LAT - 1) tick();
    #1;
    exp_d = 43'd1 << 41;
    check("extreme_valid", 64'(res_valid), 64'd1);
    check("extreme_data",  64'(res_data),  64'(exp_d));
    tick();
    repeat (2) tick();

    // Counter wrap
    res_ready = 1'b0;
    req_valid = 4'b0001;
    repeat (2) begin
      a_in[0] = 25'($urandom);
      b_in[0] = 18'($urandom);
      tick();
    end
    req_valid = '0;
    tick();
    force dut.ops_done_q = 32'hFFFF_FFFF;
    ops_m = 32'hFFFF_FFFF;
    #1;
    release dut.ops_done_q;
    res_ready = 1'b1;
    repeat (3) tick();
    #1;
    check("ops_wrap", 64'(ops_done), 64'd1);

    // Reset with two results in flight
    req_valid = 4'b0011;
    repeat (2) begin
      for (int i = 0; i < N; i++) begin
        a_in[i] = 25'($urandom);
        b_in[i] = 18'($urandom);
      end
      tick();
    end
    req_valid = '0;
    tick();
    #1;
    check("pre_rst_valid", 64'(res_valid), 64'd1);
    rst_n     = 1'b0;
    req_valid = 4'b1100;
    #1;
    check("mid_rst_valid", 64'(res_valid), 64'd0);
    check("mid_rst_ready", 64'(req_ready), 64'd0);
    check("mid_rst_ce",    64'(dsp_ce),    64'd1);
    check("mid_rst_id",    64'(res_id),    64'd0);
    check("mid_rst_ops",   64'(ops_done),  64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    check("post_rst_grant", 64'(req_ready), 64'b0100);
    tick();
    req_valid = '0;
    repeat (5) tick();

    // Randomized traffic with random back-pressure
    for (int k = 0; k < 400; k++) begin
      req_valid = 4'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        a_in[i] = 25'($urandom);
        b_in[i] = 18'($urandom);
      end
      tick();
    end
    req_valid = '0;
    res_ready = 1'b1;
    repeat (8) tick();
    check("final_empty", 64'(q_id.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1);
  end

endmodule
